// File: rtl/spi_slave_rx.sv
// SPI (CPOL=1) slave receiver: oversamples cs/sck/mosi on clk, emits each MSB-first word with a one-cycle strobe.
// Optional reply path on miso under SPI_SLAVE_RX_MISO_EN; without it miso is tied high and tx_data is ignored.
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  sck,
    input  logic                  mosi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data
);
    localparam int            CW         = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(DATA_WIDTH - 1);
    localparam logic [1:0]    FLUSH_DONE = 2'(SYNC_STAGES);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    cs_prev_q, cs_prev_d;
    logic                    sck_prev_q, sck_prev_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    done_q, done_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    armed_q, armed_d;
    logic [1:0]              flush_q, flush_d;

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sck_fall, sck_rise;
    logic frame_start, word_done;

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign sck_rise = sck_s & ~sck_prev_q;

    // The preset synchronizer would fake a cs fall if reset lands mid-frame; only accept
    // a frame start once the chain has flushed and cs has been seen high.
    assign frame_start = (state_q == IDLE) && cs_fall && armed_q;
    assign word_done   = (state_q == SHIFT) && sck_rise && (cnt_q == LAST_BIT);

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_prev_d   = cs_s;
        sck_prev_d  = sck_s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        done_d      = 1'b0;
        rx_valid_d  = done_q;
        frame_err_d = 1'b0;
        flush_d     = (flush_q == FLUSH_DONE) ? flush_q : flush_q + 2'd1;
        armed_d     = armed_q | ((flush_q == FLUSH_DONE) & cs_s);

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (word_done) begin
                        cnt_d     = '0;
                        rx_data_d = shift_d;
                        done_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (cnt_d != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '1;
            mosi_sync_q <= '1;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            done_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            armed_q     <= 1'b0;
            flush_q     <= 2'd0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            done_q      <= done_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            armed_q     <= armed_d;
            flush_q     <= flush_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == SHIFT);

`ifdef SPI_SLAVE_RX_MISO_EN
    logic [DATA_WIDTH-1:0] tx_q, tx_d;

    // With CPOL=1 every bit starts with an sck fall, so the first fall of a word must
    // not shift or the MSB presented at load would be lost.
    always_comb begin
        tx_d = tx_q;
        if (frame_start || word_done) begin
            tx_d = tx_data;
        end else if ((state_q == SHIFT) && sck_fall && (cnt_q != '0)) begin
            tx_d = {tx_q[DATA_WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q <= '1;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign miso = (state_q == SHIFT) ? tx_q[DATA_WIDTH-1] : 1'b1;
`else
    logic unused_tx;
    assign unused_tx = ^tx_data;
    assign miso      = 1'b1;
`endif
endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: an SPI master task drives frames; a bit-stream model predicts words,
// strobe cycles and truncation errors, and a compare loop checks the DUT every clk cycle.
module tb_spi_slave_rx;
    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset, cs, sck, mosi;
    logic [DW-1:0] tx_data, rx_data;
    logic          rx_valid, frame_err, busy, miso;

    int   checks = 0, failures = 0, cyc = 0;
    logic [7:0] exp_word [512];
    int   exp_cyc [512];
    int   wr = 0, rd = 0, exp_err = 0, seen_err = 0;
    bit   checking = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sck(sck), .mosi(mosi),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .busy(busy), .miso(miso), .tx_data(tx_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master: bits[n-1] goes first; reset pulse after bit index rst_at (-1 = none);
    // simul raises cs together with the final sck rise.
    task automatic frame(input logic [31:0] bits, input int n, input int half,
                         input int rst_at, input bit simul);
        logic [7:0] word;
        logic [7:0] txw;
        int         k;
        bit         aborted;
        word = '0; k = 0; aborted = 1'b0; txw = tx_data;
        cs = 1'b0;
        tick(half);
        for (int i = 0; i < n; i++) begin
            sck  = 1'b0;
            mosi = bits[n-1-i];
            tick(half);
`ifdef SPI_SLAVE_RX_MISO_EN
            if (!aborted) chk("miso_bit", miso, txw[7-k]);
`endif
            if (!aborted && i == n-1 && !simul) chk("busy_in_frame", busy, 1);
            sck = 1'b1;
            if (!aborted) begin
                word = {word[6:0], mosi};
                k++;
                if (k == DW) begin
                    exp_word[wr] = word;
                    exp_cyc[wr]  = cyc + SS + 2;
                    wr++;
                    k = 0;
                end
            end
            if (simul && i == n-1) cs = 1'b1;
            tick(half);
            if (i == rst_at) begin
                reset = 1'b1;
                tick(1);
                reset   = 1'b0;
                aborted = 1'b1;
            end
        end
        cs = 1'b1;
        if (!aborted && k != 0) exp_err++;
        tick(2*half + 4);
        chk("busy_after_frame", busy, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; cs = 1'b1; sck = 1'b1; mosi = 1'b1; tx_data = 8'hC3;
        fork
            forever begin
                @(negedge clk);
                if (checking) begin
                    if (rx_valid) begin
                        if (rd >= wr) begin
                            chk("unexpected_rx_valid", rx_valid, 0);
                        end else begin
                            chk("rx_data_word", rx_data, exp_word[rd]);
                            chk("rx_valid_latency", cyc, exp_cyc[rd]);
                            rd++;
                        end
                    end
                    if (frame_err) begin
                        if (seen_err >= exp_err) chk("unexpected_frame_err", frame_err, 0);
                        else seen_err++;
                    end
`ifndef SPI_SLAVE_RX_MISO_EN
                    chk("miso_tied_high", miso, 1);
`endif
                end
            end
        join_none

        tick(3);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_busy", busy, 0);
        chk("reset_miso", miso, 1);
        reset = 1'b0;
        tick(6);
        checking = 1'b1;

        frame(32'hA5, 8, 4, -1, 1'b0);
        chk("lit_rx_a5", rx_data, 8'hA5);
        chk("lit_words_a5", rd, 1);

        frame(32'h3CFF, 16, 4, -1, 1'b0);
        chk("lit_rx_ff", rx_data, 8'hFF);
        chk("lit_words_b2b", rd, 3);

        frame(32'h1E, 5, 4, -1, 1'b0);
        chk("lit_rx_hold", rx_data, 8'hFF);
        chk("lit_err_trunc", seen_err, 1);
        chk("lit_words_trunc", rd, 3);

        frame(32'h81, 8, 4, -1, 1'b0);
        chk("lit_rx_81", rx_data, 8'h81);

        frame(32'h55, 8, 4, 3, 1'b0);
        frame(32'h12, 8, 4, -1, 1'b0);
        chk("lit_rx_12", rx_data, 8'h12);
        chk("lit_err_after_reset", seen_err, 1);
        chk("lit_words_reset", rd, 5);

        repeat (4) begin
            sck = 1'b0; tick(4);
            sck = 1'b1; tick(4);
        end
        frame(32'h00, 8, 4, -1, 1'b0);
        chk("lit_rx_00", rx_data, 8'h00);
        chk("lit_words_idle_sck", rd, 6);

        frame(32'h96, 8, 4, -1, 1'b1);
        chk("lit_rx_simul", rx_data, 8'h96);
        chk("lit_err_simul", seen_err, 1);

        tx_data = 8'hC3;
        frame(32'h5A, 8, 5, -1, 1'b0);
        chk("lit_rx_5a", rx_data, 8'h5A);

        repeat (30) begin
            tx_data = DW'($urandom);
            n = $urandom_range(1, 20);
            frame($urandom, n, $urandom_range(4, 6), -1,
                  (n % DW == 0) && ($urandom_range(0, 2) == 0));
        end

        tick(20);
        checking = 1'b0;
        chk("all_words_seen", rd, wr);
        chk("frame_err_count", seen_err, exp_err);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
